ls_issue_arbiter: RTL and testbench

LS_ISSUE_ARBITER -- requirements
Module: ls_issue_arbiter

---
 rtl/ls_issue_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ls_issue_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ls_issue_arbiter.sv
// Load/store issue arbiter: round-robin selection between the load and store
// reservation stations into a single registered issue slot feeding the LS unit.
// Tracks stall statistics and flags a sticky timeout on excessive back-pressure.
module ls_issue_arbiter #(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         valid_rq0,
  input  logic         valid_rq1,
  input  logic [158:0] pkt_rq0,
  input  logic [158:0] pkt_rq1,
  output logic         ready_rq0,
  output logic         ready_rq1,
  input  logic         stop_ls,
  output logic         valid_out,
  output logic [6:0]   opcode_out,
  output logic [5:0]   tag_out,
  output logic [63:0]  rs1_out,
  output logic [63:0]  rs2_out,
  output logic [5:0]   rd_out,
  output logic [11:0]  imm_out,
  output logic [1:0]   state_o,
  output logic         err_timeout,
  output logic [15:0]  issued_cnt,
  output logic [15:0]  stall_cnt_total
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StStall = 2'd2
  } state_e;

  logic         valid_q, valid_d;
  logic [158:0] pkt_q, pkt_d;
  logic         prio_q, prio_d;
  state_e       state_q, state_d;
  logic         err_q, err_d;
  logic [7:0]   stop_cnt_q, stop_cnt_d;
  logic [15:0]  issued_q, issued_d;
  logic [15:0]  stall_tot_q, stall_tot_d;
  // Low from reset until the first clock edge after release; blocks grants
  // so nothing transfers on the release edge itself.
  logic         armed_q;

  logic slot_free;
  logic load_en;
  logic consume;
  logic win_vld;
  logic win_sel;

  // A stopped unit freezes the slot even when it is empty, so loading also
  // requires stop_ls low; this keeps ready low throughout any stall.
  assign slot_free = ~valid_q | ~stop_ls;
  assign load_en   = slot_free & ~stop_ls & armed_q;
  assign consume   = valid_q & ~stop_ls;

  // Round-robin winner: the prio pointer wins if valid, else the other requester.
  always_comb begin
    win_vld = 1'b0;
    win_sel = prio_q;
    if (!prio_q) begin
      if (valid_rq0) begin
        win_vld = 1'b1;
        win_sel = 1'b0;
      end else if (valid_rq1) begin
        win_vld = 1'b1;
        win_sel = 1'b1;
      end
    end else begin
      if (valid_rq1) begin
        win_vld = 1'b1;
        win_sel = 1'b1;
      end else if (valid_rq0) begin
        win_vld = 1'b1;
        win_sel = 1'b0;
      end
    end
  end

  // Combinational grants: at most one high, only when the slot can take a packet.
  always_comb begin
    ready_rq0 = load_en & win_vld & ~win_sel;
    ready_rq1 = load_en & win_vld & win_sel;
  end

  // Next-state for the issue slot, pointer, status and counters.
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    prio_d  = prio_q;
    if (load_en) begin
      if (win_vld) begin
        valid_d = 1'b1;
        pkt_d   = win_sel ? pkt_rq1 : pkt_rq0;
        prio_d  = ~win_sel;
      end else begin
        // Payload is left as-is; only the valid flag drops.
        valid_d = 1'b0;
      end
    end

    if (stop_ls) begin
      state_d = StStall;
    end else if (valid_d) begin
      state_d = StIssue;
    end else begin
      state_d = StIdle;
    end

    if (stop_ls) begin
      stop_cnt_d = (stop_cnt_q == 8'hFF) ? stop_cnt_q : stop_cnt_q + 8'd1;
    end else begin
      stop_cnt_d = 8'd0;
    end
    err_d = err_q | ({24'd0, stop_cnt_d} > STALL_LIMIT);

    issued_d    = consume ? issued_q + 16'd1 : issued_q;
    stall_tot_d = (stop_ls && valid_q) ? stall_tot_q + 16'd1 : stall_tot_q;
  end

  // State registers; reset discards any held packet immediately.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      valid_q     <= 1'b0;
      pkt_q       <= '0;
      prio_q      <= 1'b0;
      state_q     <= StIdle;
      err_q       <= 1'b0;
      stop_cnt_q  <= 8'd0;
      issued_q    <= 16'd0;
      stall_tot_q <= 16'd0;
      armed_q     <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pkt_q       <= pkt_d;
      prio_q      <= prio_d;
      state_q     <= state_d;
      err_q       <= err_d;
      stop_cnt_q  <= stop_cnt_d;
      issued_q    <= issued_d;
      stall_tot_q <= stall_tot_d;
      armed_q     <= 1'b1;
    end
  end

  assign valid_out       = valid_q;
  assign opcode_out      = pkt_q[158:152];
  assign tag_out         = pkt_q[151:146];
  assign rs1_out         = pkt_q[145:82];
  assign rs2_out         = pkt_q[81:18];
  assign rd_out          = pkt_q[17:12];
  assign imm_out         = pkt_q[11:0];
  assign state_o         = state_q;
  assign err_timeout     = err_q;
  assign issued_cnt      = issued_q;
  assign stall_cnt_total = stall_tot_q;

endmodule

// File: tb/tb_ls_issue_arbiter.sv
// Directed bench for ls_issue_arbiter: table of per-cycle vectors plus
// hand-written stall, timeout and mid-stall reset sequences.
module tb_ls_issue_arbiter;

  logic         clk;
  logic         res_n;
  logic         valid_rq0, valid_rq1;
  logic [158:0] pkt_rq0, pkt_rq1;
  logic         ready_rq0, ready_rq1;
  logic         stop_ls;
  logic         valid_out;
  logic [6:0]   opcode_out;
  logic [5:0]   tag_out;
  logic [63:0]  rs1_out, rs2_out;
  logic [5:0]   rd_out;
  logic [11:0]  imm_out;
  logic [1:0]   state_o;
  logic         err_timeout;
  logic [15:0]  issued_cnt, stall_cnt_total;

  int checks;
  int failures;

  ls_issue_arbiter #(.STALL_LIMIT(15)) dut (
    .clk             (clk),
    .res_n           (res_n),
    .valid_rq0       (valid_rq0),
    .valid_rq1       (valid_rq1),
    .pkt_rq0         (pkt_rq0),
    .pkt_rq1         (pkt_rq1),
    .ready_rq0       (ready_rq0),
    .ready_rq1       (ready_rq1),
    .stop_ls         (stop_ls),
    .valid_out       (valid_out),
    .opcode_out      (opcode_out),
    .tag_out         (tag_out),
    .rs1_out         (rs1_out),
    .rs2_out         (rs2_out),
    .rd_out          (rd_out),
    .imm_out         (imm_out),
    .state_o         (state_o),
    .err_timeout     (err_timeout),
    .issued_cnt      (issued_cnt),
    .stall_cnt_total (stall_cnt_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [5:0]  t0;
    logic [5:0]  t1;
    logic        stop;
    logic        er0;
    logic        er1;
    logic        evout;
    logic [5:0]  etag;
    logic [1:0]  est;
    logic [15:0] eiss;
  } vec_t;

  vec_t vecs[9];

  // Distinct payload per tag so every field slice is exercised.
  function automatic logic [158:0] mkpkt(input logic [5:0] t);
    logic [63:0] r1;
    r1 = {32'hDEAD_BEEF, 26'd0, t};
    return {1'b1, t, t, r1, ~r1, ~t, 6'h2A, t};
  endfunction

  task automatic chk(input string name, input logic [158:0] act, input logic [158:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive at negedge, check grants before the edge, check outputs #1 after it.
  task automatic step(input logic v0, input logic v1, input logic [5:0] t0,
                      input logic [5:0] t1, input logic stop, input logic er0,
                      input logic er1, input logic evout, input logic [5:0] etag,
                      input logic [1:0] est, input logic [15:0] eiss);
    @(negedge clk);
    valid_rq0 = v0;
    valid_rq1 = v1;
    pkt_rq0   = mkpkt(t0);
    pkt_rq1   = mkpkt(t1);
    stop_ls   = stop;
    #1;
    chk("ready_rq0", 159'(ready_rq0), 159'(er0));
    chk("ready_rq1", 159'(ready_rq1), 159'(er1));
    @(posedge clk);
    #1;
    chk("valid_out", 159'(valid_out), 159'(evout));
    if (evout) begin
      chk("payload", {opcode_out, tag_out, rs1_out, rs2_out, rd_out, imm_out}, mkpkt(etag));
    end
    chk("state_o", 159'(state_o), 159'(est));
    chk("issued_cnt", 159'(issued_cnt), 159'(eiss));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;

    // {v0, v1, t0, t1, stop, ready0, ready1, valid_out, tag, state, issued}
    // Both valid: alternating rq0, rq1, rq0, rq1, then drain.
    vecs[0] = '{1'b1, 1'b1, 6'd1, 6'd2, 1'b0, 1'b1, 1'b0, 1'b1, 6'd1, 2'd1, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 6'd3, 6'd4, 1'b0, 1'b0, 1'b1, 1'b1, 6'd4, 2'd1, 16'd1};
    vecs[2] = '{1'b1, 1'b1, 6'd5, 6'd6, 1'b0, 1'b1, 1'b0, 1'b1, 6'd5, 2'd1, 16'd2};
    vecs[3] = '{1'b1, 1'b1, 6'd7, 6'd8, 1'b0, 1'b0, 1'b1, 1'b1, 6'd8, 2'd1, 16'd3};
    vecs[4] = '{1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 16'd4};
    // Only rq1 valid, tags 5,6,7 back to back.
    vecs[5] = '{1'b0, 1'b1, 6'd0, 6'd5, 1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 2'd1, 16'd4};
    vecs[6] = '{1'b0, 1'b1, 6'd0, 6'd6, 1'b0, 1'b0, 1'b1, 1'b1, 6'd6, 2'd1, 16'd5};
    vecs[7] = '{1'b0, 1'b1, 6'd0, 6'd7, 1'b0, 1'b0, 1'b1, 1'b1, 6'd7, 2'd1, 16'd6};
    // Tag 9 enters the slot ahead of the stall sequence.
    vecs[8] = '{1'b1, 1'b0, 6'd9, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd9, 2'd1, 16'd7};

    res_n     = 1'b0;
    valid_rq0 = 1'b1;
    valid_rq1 = 1'b1;
    pkt_rq0   = mkpkt(6'd1);
    pkt_rq1   = mkpkt(6'd2);
    stop_ls   = 1'b0;

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid_out", 159'(valid_out), 159'(0));
    chk("rst_payload", {opcode_out, tag_out, rs1_out, rs2_out, rd_out, imm_out}, 159'(0));
    chk("rst_state", 159'(state_o), 159'(0));
    chk("rst_err", 159'(err_timeout), 159'(0));
    chk("rst_issued", 159'(issued_cnt), 159'(0));
    chk("rst_stall_tot", 159'(stall_cnt_total), 159'(0));
    chk("rst_ready0", 159'(ready_rq0), 159'(0));
    chk("rst_ready1", 159'(ready_rq1), 159'(0));

    // Release: no grant until the first edge after release.
    @(negedge clk);
    res_n = 1'b1;
    #1;
    chk("rel_ready0", 159'(ready_rq0), 159'(0));
    chk("rel_ready1", 159'(ready_rq1), 159'(0));
    @(posedge clk);
    #1;
    chk("rel_valid_out", 159'(valid_out), 159'(0));

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v0, vecs[i].v1, vecs[i].t0, vecs[i].t1, vecs[i].stop, vecs[i].er0,
           vecs[i].er1, vecs[i].evout, vecs[i].etag, vecs[i].est, vecs[i].eiss);
    end

    // Tag 9 held under 16 consecutive stop edges; timeout trips on the 16th.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 6'd20, 6'd21, 1'b1, 1'b0, 1'b0, 1'b1, 6'd9, 2'd2, 16'd7);
      chk("stall_cnt_total", 159'(stall_cnt_total), 159'(i + 1));
      chk("err_timeout_stall", 159'(err_timeout), 159'(i == 15));
    end

    // Stop drops: tag 9 consumed, error stays sticky.
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 16'd8);
    chk("err_sticky", 159'(err_timeout), 159'(1));
    chk("stall_cnt_hold", 159'(stall_cnt_total), 159'(16));

    // Load tag 11 via rq0 (prio moves to rq1), then stall with the slot full.
    step(1'b1, 1'b0, 6'd11, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd11, 2'd1, 16'd8);
    step(1'b1, 1'b1, 6'd12, 6'd13, 1'b1, 1'b0, 1'b0, 1'b1, 6'd11, 2'd2, 16'd8);
    step(1'b1, 1'b1, 6'd12, 6'd13, 1'b1, 1'b0, 1'b0, 1'b1, 6'd11, 2'd2, 16'd8);
    chk("stall_cnt_pre_rst", 159'(stall_cnt_total), 159'(18));

    // Asynchronous reset mid-stall, away from any clock edge.
    @(negedge clk);
    #2;
    res_n = 1'b0;
    #1;
    chk("arst_valid_out", 159'(valid_out), 159'(0));
    chk("arst_issued", 159'(issued_cnt), 159'(0));
    chk("arst_stall_tot", 159'(stall_cnt_total), 159'(0));
    chk("arst_err", 159'(err_timeout), 159'(0));
    chk("arst_state", 159'(state_o), 159'(0));
    chk("arst_ready0", 159'(ready_rq0), 159'(0));
    chk("arst_ready1", 159'(ready_rq1), 159'(0));

    @(posedge clk);
    @(negedge clk);
    stop_ls = 1'b0;
    res_n   = 1'b1;
    #1;
    chk("arel_ready0", 159'(ready_rq0), 159'(0));
    chk("arel_ready1", 159'(ready_rq1), 159'(0));
    @(posedge clk);
    #1;
    chk("arel_valid_out", 159'(valid_out), 159'(0));

    // Pointer reset to rq0: rq0 wins even though it won last before reset.
    step(1'b1, 1'b1, 6'd14, 6'd15, 1'b0, 1'b1, 1'b0, 1'b1, 6'd14, 2'd1, 16'd0);
    step(1'b1, 1'b1, 6'd16, 6'd17, 1'b0, 1'b0, 1'b1, 1'b1, 6'd17, 2'd1, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
